// File: rtl/logic_op_pkg.sv
// Shared op codes and the bitwise op function for the logic op stream.
// Latency: n/a (combinational helpers only).
// Backpressure: n/a.
package logic_op_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND  = 3'd0;
    localparam op_t OP_OR   = 3'd1;
    localparam op_t OP_XNOR = 3'd2;
    localparam op_t OP_XOR  = 3'd3;
    localparam op_t OP_NAND = 3'd4;
    localparam op_t OP_NOR  = 3'd5;
    localparam op_t OP_ANDN = 3'd6;
    localparam op_t OP_PASS = 3'd7;

    // Widest operand the function handles; callers zero-extend their W-bit
    // operands and cast the result back to W bits, so any W up to this works.
    localparam int MAX_W = 64;

    function automatic logic [MAX_W-1:0] logic_op_f(
        input op_t              op,
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b
    );
        logic [MAX_W-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XNOR: r = ~(a ^ b);
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_ANDN: r = a & ~b;
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_op_stream_if.sv
// Operand/result stream bundle between producer, logic op block and consumer.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
interface logic_op_stream_if #(
    parameter int W = 8
) ();
    import logic_op_pkg::*;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_zero;
    op_t          out_op;

    // Producer + consumer side (drives operands, accepts results)
    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_op
    );

    // Logic op block side
    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_op
    );

endinterface

// File: rtl/logic_op_stream_fifo.sv
// Synchronous FIFO, power-of-2 depth, head presented directly from storage.
// Latency: push visible at head the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty.
module logic_op_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Next storage, pointers (wrap naturally at DEPTH) and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared on reset so the head reads as zero afterwards
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/logic_op_stream.sv
// Streaming bitwise logic unit: op register, result FIFO, zero flag, saturating beat counter.
// Latency: 1 cycle from accept edge to result at FIFO head.
// Backpressure: in_ready is a registered (count < DEPTH); it never depends on out_ready combinationally.
module logic_op_stream
    import logic_op_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  op_t                cfg_op,
    input  logic               cfg_clr,
    output op_t                op_q,
    output logic [CNT_W-1:0]   beat_cnt,
    logic_op_stream_if.slave   strm
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = W + 4;

    op_t              op_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             in_ready_q, in_ready_d;

    logic             accept, pop;
    logic [W-1:0]     result;
    logic             result_zero;
    logic [EW-1:0]    push_dat, pop_dat;
    logic [CW-1:0]    fifo_count, count_nxt;
    logic             fifo_full, fifo_empty;

    // in_ready already implies room; the full term only guards against misuse
    assign accept = strm.in_valid & in_ready_q & ~fifo_full;
    assign pop    = ~fifo_empty & strm.out_ready;

    // Result uses the op register as it stands before any same-cycle cfg write
    assign result      = W'(logic_op_f(op_q, MAX_W'(strm.in_a), MAX_W'(strm.in_b)));
    assign result_zero = ~|result;
    assign push_dat    = {op_q, result_zero, result};

    logic_op_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (accept),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (pop_dat),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign strm.out_valid = ~fifo_empty;
    assign strm.out_op    = pop_dat[EW-1 -: 3];
    assign strm.out_zero  = pop_dat[W];
    assign strm.out_data  = pop_dat[W-1:0];
    assign strm.in_ready  = in_ready_q;
    assign beat_cnt       = beat_cnt_q;

    // Op register load, beat counter (clear wins, saturates), next ready from next occupancy
    always_comb begin
        op_d       = op_q;
        beat_cnt_d = beat_cnt_q;
        count_nxt  = fifo_count;
        in_ready_d = 1'b0;
        if (cfg_we) begin
            op_d = cfg_op;
        end
        if (cfg_clr) begin
            beat_cnt_d = '0;
        end else if (accept && (beat_cnt_q != '1)) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
        if (accept && !pop) begin
            count_nxt = fifo_count + CW'(1);
        end else if (pop && !accept) begin
            count_nxt = fifo_count - CW'(1);
        end
        in_ready_d = (count_nxt < CW'(DEPTH));
    end

    // Control state; reset drops in_ready so nothing is taken until the first clean edge
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= OP_AND;
            beat_cnt_q <= '0;
            in_ready_q <= 1'b0;
        end else begin
            op_q       <= op_d;
            beat_cnt_q <= beat_cnt_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_logic_op_stream.sv
// Scoreboard bench for logic_op_stream: one task per scenario, expected results
// queued at accept time from a local op model and compared when the head pops.
module tb_logic_op_stream;
    import logic_op_pkg::*;

    typedef logic [11:0] ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    op_t         cfg_op = 3'd0;
    logic        cfg_clr = 1'b0;
    op_t         op_q;
    logic [15:0] beat_cnt;

    logic        cfg_clr2 = 1'b0;
    logic        cfg_we2 = 1'b0;
    op_t         cfg_op2 = 3'd0;
    op_t         op_q2;
    logic [2:0]  beat_cnt2;

    int          errs = 0;
    int          checks = 0;

    ent_t        sb[$];
    ent_t        got, exp_e;
    logic        acc, pop, rdy_s;
    op_t         tb_op = 3'd0;
    logic [15:0] tb_cnt = 16'd0;

    logic_op_stream_if #(.W(8)) bus();
    logic_op_stream_if #(.W(8)) bus2();

    logic_op_stream #(.W(8), .DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_op(cfg_op), .cfg_clr(cfg_clr),
        .op_q(op_q), .beat_cnt(beat_cnt), .strm(bus)
    );

    logic_op_stream #(.W(8), .DEPTH(4), .CNT_W(3)) dut_cnt (
        .clk(clk), .rst(rst), .cfg_we(cfg_we2), .cfg_op(cfg_op2), .cfg_clr(cfg_clr2),
        .op_q(op_q2), .beat_cnt(beat_cnt2), .strm(bus2)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model(input op_t op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return ~(a ^ b);
            3'd3: return a ^ b;
            3'd4: return ~(a & b);
            3'd5: return ~(a | b);
            3'd6: return a & ~b;
            default: return a;
        endcase
    endfunction

    // One clock: observe handshakes at negedge, advance model at posedge, return #1 later
    task automatic tick();
        logic [7:0] r;
        @(negedge clk);
        acc   = bus.in_valid & bus.in_ready;
        pop   = bus.out_valid & bus.out_ready;
        rdy_s = bus.in_ready;
        got   = {bus.out_op, bus.out_zero, bus.out_data};
        r     = model(tb_op, bus.in_a, bus.in_b);
        @(posedge clk);
        if (rst) begin
            sb.delete();
            tb_op  = 3'd0;
            tb_cnt = 16'd0;
            pop    = 1'b0;
        end else begin
            if (acc) sb.push_back({tb_op, (r == 8'h00), r});
            if (cfg_clr) tb_cnt = 16'd0;
            else if (acc && tb_cnt != 16'hFFFF) tb_cnt = tb_cnt + 16'd1;
            if (cfg_we) tb_op = cfg_op;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (op_q !== 3'd0) begin errs++; $display("FAIL rst_op_q got=%0d exp=0", op_q); end
        checks++; if (beat_cnt !== 16'd0) begin errs++; $display("FAIL rst_beat_cnt got=%0d exp=0", beat_cnt); end
        checks++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if ({bus.out_op, bus.out_zero, bus.out_data} !== 12'h000) begin errs++; $display("FAIL rst_out_fields got=%h exp=000", {bus.out_op, bus.out_zero, bus.out_data}); end
        rst = 1'b0;
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL post_rst_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus2.in_ready !== 1'b1) begin errs++; $display("FAIL post_rst_in_ready2 got=%b exp=1", bus2.in_ready); end
    endtask

    task automatic test_all_ops();
        logic [7:0] exp_tab [8];
        exp_tab = '{8'h42, 8'hDB, 8'h66, 8'h99, 8'hBD, 8'h24, 8'h81, 8'hC3};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cfg_we = 1'b1; cfg_op = op_t'(i); bus.in_valid = 1'b0;
            tick();
            if (pop) begin checks++; exp_e = sb.pop_front(); if (got !== exp_e) begin errs++; $display("FAIL ops_sb got=%h exp=%h", got, exp_e); end end
            cfg_we = 1'b0; bus.in_valid = 1'b1; bus.in_a = 8'hC3; bus.in_b = 8'h5A;
            tick();
            bus.in_valid = 1'b0;
            checks++; if (bus.out_valid !== 1'b1) begin errs++; $display("FAIL ops_latency op=%0d got=%b exp=1", i, bus.out_valid); end
            checks++; if (bus.out_data !== exp_tab[i] || bus.out_zero !== 1'b0 || bus.out_op !== op_t'(i))
                begin errs++; $display("FAIL ops_result op=%0d got=%h/%b/%0d exp=%h/0/%0d", i, bus.out_data, bus.out_zero, bus.out_op, exp_tab[i], i); end
            tick();
            if (pop) begin checks++; exp_e = sb.pop_front(); if (got !== exp_e) begin errs++; $display("FAIL ops_sb got=%h exp=%h", got, exp_e); end end
        end
    endtask

    task automatic test_backpressure();
        int n_acc = 0;
        int n_pop = 0;
        cfg_clr = 1'b1; cfg_we = 1'b1; cfg_op = 3'd3;
        tick();
        cfg_clr = 1'b0; cfg_we = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1; bus.in_a = 8'(i * 16 + 1); bus.in_b = 8'h0F;
            tick();
            if (acc) n_acc++;
        end
        bus.in_valid = 1'b0;
        checks++; if (n_acc != 4) begin errs++; $display("FAIL bp_accepted got=%0d exp=4", n_acc); end
        checks++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL bp_in_ready_full got=%b exp=0", bus.in_ready); end
        checks++; if (beat_cnt !== 16'd4) begin errs++; $display("FAIL bp_beat_cnt got=%0d exp=4", beat_cnt); end
        bus.out_ready = 1'b1;
        tick();
        checks++; if (rdy_s !== 1'b0) begin errs++; $display("FAIL bp_ready_pop_cycle got=%b exp=0", rdy_s); end
        checks++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL bp_ready_after_pop got=%b exp=1", bus.in_ready); end
        if (pop) begin n_pop++; checks++; exp_e = sb.pop_front(); if (got !== exp_e) begin errs++; $display("FAIL bp_sb got=%h exp=%h", got, exp_e); end end
        for (int k = 0; k < 10 && sb.size() != 0; k++) begin
            tick();
            if (pop) begin n_pop++; checks++; exp_e = sb.pop_front(); if (got !== exp_e) begin errs++; $display("FAIL bp_sb got=%h exp=%h", got, exp_e); end end
        end
        checks++; if (n_pop != 4) begin errs++; $display("FAIL bp_drain got=%0d pops exp=4", n_pop); end
    endtask

    task automatic test_op_change();
        bus.out_ready = 1'b0; cfg_we = 1'b1; cfg_op = 3'd0;
        tick();
        cfg_we = 1'b1; cfg_op = 3'd1; bus.in_valid = 1'b1; bus.in_a = 8'hF0; bus.in_b = 8'h0F;
        tick();
        cfg_we = 1'b0;
        checks++; if (bus.out_data !== 8'h00 || bus.out_zero !== 1'b1 || bus.out_op !== 3'd0)
            begin errs++; $display("FAIL opchg_old got=%h/%b/%0d exp=00/1/0", bus.out_data, bus.out_zero, bus.out_op); end
        checks++; if (op_q !== 3'd1) begin errs++; $display("FAIL opchg_op_q got=%0d exp=1", op_q); end
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        if (pop) begin checks++; exp_e = sb.pop_front(); if (got !== exp_e) begin errs++; $display("FAIL opchg_sb got=%h exp=%h", got, exp_e); end end
        checks++; if (bus.out_data !== 8'hFF || bus.out_zero !== 1'b0 || bus.out_op !== 3'd1)
            begin errs++; $display("FAIL opchg_new got=%h/%b/%0d exp=FF/0/1", bus.out_data, bus.out_zero, bus.out_op); end
        tick();
        if (pop) begin checks++; exp_e = sb.pop_front(); if (got !== exp_e) begin errs++; $display("FAIL opchg_sb got=%h exp=%h", got, exp_e); end end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = (i < 8) ? 1'b1 : ($urandom_range(0, 2) != 0);
            bus.in_a = 8'($urandom); bus.in_b = 8'($urandom);
            cfg_we = ($urandom_range(0, 5) == 0); cfg_op = op_t'($urandom_range(0, 7));
            tick();
            if (pop) begin checks++; exp_e = sb.pop_front(); if (got !== exp_e) begin errs++; $display("FAIL b2b_sb got=%h exp=%h", got, exp_e); end end
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; cfg_we = 1'b0;
        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            tick();
            if (pop) begin checks++; exp_e = sb.pop_front(); if (got !== exp_e) begin errs++; $display("FAIL b2b_sb got=%h exp=%h", got, exp_e); end end
        end
        checks++; if (sb.size() != 0 || bus.out_valid !== 1'b0) begin errs++; $display("FAIL b2b_drain left=%0d out_valid=%b exp=0/0", sb.size(), bus.out_valid); end
        checks++; if (beat_cnt !== tb_cnt) begin errs++; $display("FAIL b2b_beat_cnt got=%0d exp=%0d", beat_cnt, tb_cnt); end
    endtask

    task automatic test_counter();
        bus2.in_valid = 1'b1; bus2.out_ready = 1'b1; bus2.in_a = 8'h11; bus2.in_b = 8'h22;
        repeat (9) tick();
        checks++; if (beat_cnt2 !== 3'd7) begin errs++; $display("FAIL cnt_saturate got=%0d exp=7", beat_cnt2); end
        cfg_clr2 = 1'b1;
        tick();
        cfg_clr2 = 1'b0;
        checks++; if (beat_cnt2 !== 3'd0) begin errs++; $display("FAIL cnt_clr_priority got=%0d exp=0", beat_cnt2); end
        tick();
        bus2.in_valid = 1'b0;
        checks++; if (beat_cnt2 !== 3'd1) begin errs++; $display("FAIL cnt_after_clr got=%0d exp=1", beat_cnt2); end
    endtask

    task automatic test_midstream_reset();
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_a = 8'h5A; bus.in_b = 8'hA5;
        repeat (3) tick();
        checks++; if (bus.out_valid !== 1'b1 || sb.size() != 3) begin errs++; $display("FAIL mid_prefill out_valid=%b entries=%0d exp=1/3", bus.out_valid, sb.size()); end
        rst = 1'b1;
        tick();
        rst = 1'b0; bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || beat_cnt !== 16'd0 || bus.in_ready !== 1'b0)
            begin errs++; $display("FAIL mid_rst got=%b/%0d/%b exp=0/0/0", bus.out_valid, beat_cnt, bus.in_ready); end
        tick();
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errs++; $display("FAIL mid_after got=%b/%b exp=1/0", bus.in_ready, bus.out_valid); end
        bus.in_valid = 1'b1; bus.in_a = 8'h3C; bus.in_b = 8'h0F;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_data !== 8'h0C || bus.out_op !== 3'd0) begin errs++; $display("FAIL mid_fresh got=%h/%0d exp=0C/0", bus.out_data, bus.out_op); end
        bus.out_ready = 1'b1;
        tick();
        if (pop) begin checks++; exp_e = sb.pop_front(); if (got !== exp_e) begin errs++; $display("FAIL mid_sb got=%h exp=%h", got, exp_e); end end
        checks++; if (bus.out_valid !== 1'b0 || beat_cnt !== 16'd1) begin errs++; $display("FAIL mid_stale out_valid=%b beat_cnt=%0d exp=0/1", bus.out_valid, beat_cnt); end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_a = '0; bus2.in_b = '0; bus2.out_ready = 1'b0;
        test_reset();
        test_all_ops();
        test_backpressure();
        test_op_change();
        test_back_to_back();
        test_counter();
        test_midstream_reset();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errs, checks);
        $fatal(1, "timeout");
    end

endmodule
